// File: rtl/or_pulse_monitor.sv
// rtl/or_pulse_monitor.sv - synchronises the OR-gate output, counts its edges and measures high/low run widths
module or_pulse_monitor #(
    parameter int CNT_W       = 8,
    parameter int MIN_WIDTH   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             sig_in,
    output logic             sig_sync,
    output logic [CNT_W-1:0] rise_cnt,
    output logic [CNT_W-1:0] fall_cnt,
    output logic [CNT_W-1:0] last_high_w,
    output logic [CNT_W-1:0] last_low_w,
    output logic             meas_valid,
    output logic             glitch,
    output logic [CNT_W-1:0] glitch_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEAS_HIGH, MEAS_LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] MIN_W   = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_d;
    logic                   edge_seen;
    logic [CNT_W-1:0]       run_len;
    logic                   count_edge;
    logic                   report;
    logic                   is_glitch;
    logic                   run_active;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + ONE;
    endfunction

    assign sig_sync  = sync_q[SYNC_STAGES-1];
    assign edge_seen = sig_sync ^ sig_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            sig_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_d  <= sig_sync;
        end
    end

    // clr and en=0 both override edge handling; the first edge after WAIT_EDGE only arms measurement
    always_comb begin
        state_next = state;
        count_edge = 1'b0;
        report     = 1'b0;
        if (clr) begin
            state_next = en ? WAIT_EDGE : IDLE;
        end else if (!en) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: state_next = WAIT_EDGE;
                WAIT_EDGE: begin
                    if (edge_seen) begin
                        count_edge = 1'b1;
                        state_next = sig_sync ? MEAS_HIGH : MEAS_LOW;
                    end
                end
                MEAS_HIGH, MEAS_LOW: begin
                    if (edge_seen) begin
                        count_edge = 1'b1;
                        report     = 1'b1;
                        state_next = sig_sync ? MEAS_HIGH : MEAS_LOW;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
        is_glitch  = report && (run_len < MIN_W);
        run_active = !clr && en && (state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            run_len     <= '0;
            rise_cnt    <= '0;
            fall_cnt    <= '0;
            last_high_w <= '0;
            last_low_w  <= '0;
            glitch_cnt  <= '0;
            meas_valid  <= 1'b0;
            glitch      <= 1'b0;
        end else begin
            state      <= state_next;
            meas_valid <= report;
            glitch     <= is_glitch;
            if (clr) begin
                run_len     <= '0;
                rise_cnt    <= '0;
                fall_cnt    <= '0;
                last_high_w <= '0;
                last_low_w  <= '0;
                glitch_cnt  <= '0;
            end else begin
                if (run_active)
                    run_len <= edge_seen ? ONE : sat_inc(run_len);
                if (count_edge) begin
                    if (sig_sync)
                        rise_cnt <= sat_inc(rise_cnt);
                    else
                        fall_cnt <= sat_inc(fall_cnt);
                end
                if (report) begin
                    if (state == MEAS_HIGH)
                        last_high_w <= run_len;
                    else
                        last_low_w <= run_len;
                end
                if (is_glitch)
                    glitch_cnt <= sat_inc(glitch_cnt);
            end
        end
    end

endmodule
